// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : input_pkg
//  Description : Shared types and constants for the input conditioner:
//                keypad FSM state encoding, keypad geometry, counter widths,
//                and helpers that classify and encode a keypad vector.
//  Revision    : 1.0  initial release
// ============================================================================
package input_pkg;

    // Keypad geometry and output code width
    localparam int KEY_COUNT  = 10;
    localparam int KEY_CODE_W = 4;

    // Debounce counter width covers the full DEBOUNCE_CYCLES range (2..255)
    localparam int CNT_W      = 8;

    // Auto-repeat counter width, wide enough for multi-second repeat delays
    localparam int REP_CNT_W  = 16;

    // Keypad FSM states
    typedef enum logic [2:0] {
        KP_IDLE    = 3'd0,
        KP_PRESS   = 3'd1,
        KP_HELD    = 3'd2,
        KP_INVALID = 3'd3,
        KP_RELEASE = 3'd4
    } kp_state_t;

    // True when exactly one key line is active
    function automatic logic is_onehot(input logic [KEY_COUNT-1:0] v);
        return (v != '0) && ((v & (v - KEY_COUNT'(1))) == '0);
    endfunction

    // Binary index of the active key; only meaningful for a one-hot vector
    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEY_COUNT-1:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (v[i]) begin
                idx = KEY_CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : input_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : Single push-button channel: 2-FF synchronizer, saturating
//                debounce counter and a one-cycle pulse on an accepted press.
//                No pulse is produced on release.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_ch
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Count consecutive disagreements; flip the level once the count has
    // reached DB_MAX and the input still disagrees. Agreement clears it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_MAX) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Synchronizes, debounces and edge-detects the mode/start
//                buttons and the 10-line keypad, producing one-cycle pulses
//                and a validated key code.
//                Optional macro KEY_REPEAT_EN: auto-repeat of a held key.
//  Revision    : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_raw,
    input  logic                  start_raw,
    input  logic [KEY_COUNT-1:0]  keypad_raw,
    output logic                  mode_pulse,
    output logic                  start_pulse,
    output logic [KEY_COUNT-1:0]  key_pulse,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Reject out-of-range configurations at elaboration
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_chk
        $error("input_conditioner: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Button channels
    // ------------------------------------------------------------------
    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_mode_ch (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (mode_raw),
        .pulse_o (mode_pulse)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_ch (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (start_raw),
        .pulse_o (start_pulse)
    );

    // ------------------------------------------------------------------
    // Keypad: the whole vector is debounced as one value
    // ------------------------------------------------------------------
    logic [KEY_COUNT-1:0]  kp_sync1_q;
    logic [KEY_COUNT-1:0]  kp_sync2_q;

    kp_state_t             state_q,     state_d;
    logic [KEY_COUNT-1:0]  cap_q,       cap_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  prev_held_q, prev_held_d;
    logic [KEY_CODE_W-1:0] code_q,      code_d;
    logic                  held_q,      held_d;
    logic [KEY_COUNT-1:0]  kpulse_q,    kpulse_d;

    logic                  kp_any;
    logic [CNT_W-1:0]      cnt_inc;

    assign kp_any  = (kp_sync2_q != '0);
    assign cnt_inc = (cnt_q == DB_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

`ifdef KEY_REPEAT_EN
    localparam logic [REP_CNT_W-1:0] REP_DLY = REP_CNT_W'(REPEAT_DELAY);
    localparam logic [REP_CNT_W-1:0] REP_RTE = REP_CNT_W'(REPEAT_RATE);

    logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                 rep_armed_q, rep_armed_d;
`endif

    // Keypad FSM next-state and output logic
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        prev_held_d = prev_held_q;
        code_d      = code_q;
        held_d      = held_q;
        kpulse_d    = '0;
`ifdef KEY_REPEAT_EN
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
`endif

        case (state_q)
            KP_IDLE: begin
                if (kp_any) begin
                    cap_d   = kp_sync2_q;
                    cnt_d   = '0;
                    state_d = KP_PRESS;
                end
            end

            KP_PRESS: begin
                if (!kp_any) begin
                    cnt_d   = '0;
                    state_d = KP_IDLE;
                end else if (kp_sync2_q != cap_q) begin
                    cap_d = kp_sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_MAX) begin
                        cnt_d = '0;
                        if (is_onehot(cap_q)) begin
                            kpulse_d = cap_q;
                            code_d   = key_index(cap_q);
                            held_d   = 1'b1;
                            state_d  = KP_HELD;
                        end else begin
                            state_d  = KP_INVALID;
                        end
                    end
                end
            end

            KP_HELD: begin
                if (!kp_any) begin
                    cnt_d       = '0;
                    prev_held_d = 1'b1;
                    state_d     = KP_RELEASE;
                end else if (kp_sync2_q != cap_q) begin
                    held_d  = 1'b0;
                    state_d = KP_INVALID;
                end else begin
`ifdef KEY_REPEAT_EN
                    // First repeat after REP_DLY cycles, then every REP_RTE
                    rep_cnt_d   = rep_cnt_q + REP_CNT_W'(1);
                    rep_armed_d = rep_armed_q;
                    if ((!rep_armed_q && rep_cnt_d == REP_DLY) ||
                        ( rep_armed_q && rep_cnt_d == REP_RTE)) begin
                        kpulse_d    = cap_q;
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b1;
                    end
`endif
                end
            end

            KP_INVALID: begin
                if (!kp_any) begin
                    cnt_d       = '0;
                    prev_held_d = 1'b0;
                    state_d     = KP_RELEASE;
                end
            end

            KP_RELEASE: begin
                if (kp_any) begin
                    // Release bounce: resume where we were, no new pulse
                    cnt_d   = '0;
                    state_d = prev_held_q ? KP_HELD : KP_INVALID;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_MAX) begin
                        cnt_d   = '0;
                        held_d  = 1'b0;
                        state_d = KP_IDLE;
                    end
                end
            end

            default: begin
                state_d = KP_IDLE;
            end
        endcase
    end

    // Keypad synchronizer and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_sync1_q  <= '0;
            kp_sync2_q  <= '0;
            state_q     <= KP_IDLE;
            cap_q       <= '0;
            cnt_q       <= '0;
            prev_held_q <= 1'b0;
            code_q      <= '0;
            held_q      <= 1'b0;
            kpulse_q    <= '0;
        end else begin
            kp_sync1_q  <= keypad_raw;
            kp_sync2_q  <= kp_sync1_q;
            state_q     <= state_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            prev_held_q <= prev_held_d;
            code_q      <= code_d;
            held_q      <= held_d;
            kpulse_q    <= kpulse_d;
        end
    end

`ifdef KEY_REPEAT_EN
    // Auto-repeat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`endif

    assign key_pulse = kpulse_q;
    assign key_code  = code_q;
    assign key_held  = held_q;

endmodule : input_conditioner
`default_nettype wire
